// File: rtl/id_scoreboard_pkg.sv
// Shared decode-stage definitions: scoreboard FSM encoding and instruction field positions.
package id_scoreboard_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitBr = 2'd1,
    StFlush  = 2'd2
  } sb_state_e;

  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_LSB = 11;

  localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/id_scoreboard_busy_table.sv
// Per-register busy bits with set/clear update, register 0 hard-wired clear, two read ports.
module id_scoreboard_busy_table #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_reg,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_reg,
  input  logic [AW-1:0]    rd_a_reg,
  input  logic [AW-1:0]    rd_b_reg,
  output logic             rd_a,
  output logic             rd_b,
  output logic [DEPTH-1:0] busy_mask
);

  logic [DEPTH-1:0] busy_d, busy_q;

  // Clear applied first so a same-register set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_reg] = 1'b0;
    if (set_en) busy_d[set_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rd_a      = busy_q[rd_a_reg];
  assign rd_b      = busy_q[rd_b_reg];
  assign busy_mask = busy_q;

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage issue controller: RAW/WAW stalls on busy registers, branch serialisation and flush.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned REG_FILE_DEPTH = 8,
  parameter int unsigned REG_DIR_WIDTH  = 3,
  parameter int unsigned FLUSH_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [31:0]               instr,
  input  logic                      id_regwrite,
  input  logic                      id_regdst,
  input  logic                      id_branch,
  input  logic                      wb_regwrite,
  input  logic [REG_DIR_WIDTH-1:0]  wb_reg,
  input  logic                      br_resolved,
  input  logic                      br_taken,
  output logic                      issue,
  output logic                      stall,
  output logic                      flush,
  output logic [REG_FILE_DEPTH-1:0] busy_mask
);

  localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  sb_state_e              state_q;
  logic [FLUSH_CNT_W-1:0] cnt_q;

  logic [REG_DIR_WIDTH-1:0] rs, rt, rd, dest;
  logic busy_rs, busy_rt, busy_dest, hazard, set_en;
  logic unused_instr;

  assign rs   = instr[RS_LSB +: REG_DIR_WIDTH];
  assign rt   = instr[RT_LSB +: REG_DIR_WIDTH];
  assign rd   = instr[RD_LSB +: REG_DIR_WIDTH];
  assign dest = id_regdst ? rd : rt;
  assign unused_instr = ^instr;

  id_scoreboard_busy_table #(
    .DEPTH (REG_FILE_DEPTH),
    .AW    (REG_DIR_WIDTH)
  ) u_busy_table (
    .clk       (clk),
    .rst       (rst),
    .set_en    (set_en),
    .set_reg   (dest),
    .clr_en    (wb_regwrite),
    .clr_reg   (wb_reg),
    .rd_a_reg  (rs),
    .rd_b_reg  (rt),
    .rd_a      (busy_rs),
    .rd_b      (busy_rt),
    .busy_mask (busy_mask)
  );

  // Lookups use registered bits only, so a same-cycle writeback does not bypass.
  assign busy_dest = busy_mask[dest];
  assign hazard    = busy_rs | (id_regdst & busy_rt) | (id_regwrite & busy_dest);
  assign set_en    = issue & id_regwrite & (dest != '0);

  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    if (!rst) begin
      case (state_q)
        StIdle: begin
          issue = issue_valid & ~hazard;
          stall = issue_valid & hazard;
        end
        StWaitBr: stall = issue_valid;
        StFlush: begin
          flush = 1'b1;
          stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: if (issue && id_branch) state_q <= StWaitBr;
        StWaitBr: begin
          if (br_resolved) begin
            if (br_taken) begin
              state_q <= StFlush;
              cnt_q   <= FlushLoad;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StFlush: begin
          if (cnt_q == '0) state_q <= StIdle;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: hazards, register 0, branch serialisation, flush and reset.
module tb_id_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [31:0] instr;
  logic       id_regwrite, id_regdst, id_branch;
  logic       wb_regwrite;
  logic [2:0] wb_reg;
  logic       br_resolved, br_taken;
  logic       issue, stall, flush;
  logic [7:0] busy_mask;

  int errors = 0;
  int checks = 0;

  id_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .instr       (instr),
    .id_regwrite (id_regwrite),
    .id_regdst   (id_regdst),
    .id_branch   (id_branch),
    .wb_regwrite (wb_regwrite),
    .wb_reg      (wb_reg),
    .br_resolved (br_resolved),
    .br_taken    (br_taken),
    .issue       (issue),
    .stall       (stall),
    .flush       (flush),
    .busy_mask   (busy_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
    mk = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
  endfunction

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic rw, input logic rdst,
                       input logic br);
    issue_valid = v; instr = i; id_regwrite = rw; id_regdst = rdst; id_branch = br;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    wb_regwrite = 1'b0; wb_reg = 3'd0; br_resolved = 1'b0; br_taken = 1'b0;
  endtask

  task automatic wb_clear(input logic [2:0] r);
    idle();
    wb_regwrite = 1'b1; wb_reg = r;
    cyc();
    wb_regwrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, mk(1, 2, 3), 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (issue !== 1'b0 || stall !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL reset_outputs: got issue=%b stall=%b flush=%b want 000", issue, stall, flush); end
    checks++; if (busy_mask !== 8'h00) begin errors++;
      $display("FAIL reset_busy: got %h want 00", busy_mask); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
      $display("FAIL addu_issue: got issue=%b stall=%b want 1 0", issue, stall); end
    cyc();
    idle();
    checks++; if (busy_mask !== 8'b0000_1000) begin errors++;
      $display("FAIL addu_busy: got %b want 00001000", busy_mask); end
  endtask

  task automatic test_raw();
    drive(1'b1, mk(3, 0, 4), 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++;
      $display("FAIL raw_stall: got stall=%b issue=%b want 1 0", stall, issue); end
    wb_regwrite = 1'b1; wb_reg = 3'd3;
    #1;
    checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++;
      $display("FAIL raw_no_bypass: got stall=%b issue=%b want 1 0", stall, issue); end
    cyc();
    wb_regwrite = 1'b0;
    #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0 || busy_mask !== 8'h00) begin errors++;
      $display("FAIL raw_release: got issue=%b stall=%b busy=%h want 1 0 00", issue, stall, busy_mask); end
    cyc();
    idle();
    checks++; if (busy_mask !== 8'h10) begin errors++;
      $display("FAIL raw_busy4: got %h want 10", busy_mask); end
    wb_clear(3'd4);
  endtask

  task automatic test_itype();
    drive(1'b1, mk(1, 2, 5), 1'b1, 1'b1, 1'b0);
    cyc();
    drive(1'b1, mk(1, 5, 0), 1'b1, 1'b0, 1'b0);  // lw $5,0($1)
    #1;
    checks++; if (stall !== 1'b1 || issue !== 1'b0 || busy_mask !== 8'h20) begin errors++;
      $display("FAIL itype_waw: got stall=%b issue=%b busy=%h want 1 0 20", stall, issue, busy_mask); end
    wb_clear(3'd5);
    drive(1'b1, mk(1, 1, 2), 1'b1, 1'b1, 1'b0);
    cyc();
    drive(1'b1, mk(1, 6, 0), 1'b1, 1'b0, 1'b0);  // lw $6,0($1) with $2 busy
    #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0 || busy_mask !== 8'h04) begin errors++;
      $display("FAIL itype_unrelated: got issue=%b stall=%b busy=%h want 1 0 04", issue, stall, busy_mask); end
    cyc();
    drive(1'b1, mk(1, 2, 0), 1'b0, 1'b0, 1'b0);  // store-like: rt=$2 busy but not a source
    #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
      $display("FAIL itype_rt_not_src: got issue=%b stall=%b want 1 0", issue, stall); end
    cyc();
    idle();
    checks++; if (busy_mask !== 8'h44) begin errors++;
      $display("FAIL itype_busy: got %h want 44", busy_mask); end
    wb_clear(3'd2);
    wb_clear(3'd6);
  endtask

  task automatic test_reg0();
    drive(1'b1, mk(1, 2, 0), 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (issue !== 1'b1) begin errors++;
      $display("FAIL reg0_issue: got %b want 1", issue); end
    cyc();
    idle();
    checks++; if (busy_mask !== 8'h00) begin errors++;
      $display("FAIL reg0_busy: got %h want 00", busy_mask); end
    drive(1'b1, mk(1, 1, 7), 1'b1, 1'b1, 1'b0);
    cyc();
    drive(1'b1, mk(0, 0, 1), 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0 || busy_mask !== 8'h80) begin errors++;
      $display("FAIL reg0_rs: got issue=%b stall=%b busy=%h want 1 0 80", issue, stall, busy_mask); end
    cyc();
    wb_clear(3'd1);
    wb_clear(3'd7);
  endtask

  task automatic test_branch_nt();
    drive(1'b1, mk(1, 2, 0), 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (issue !== 1'b1) begin errors++;
      $display("FAIL bnt_beq_issue: got %b want 1", issue); end
    cyc();
    drive(1'b1, mk(1, 2, 3), 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++;
      $display("FAIL bnt_wait: got stall=%b issue=%b want 1 0", stall, issue); end
    cyc();
    br_resolved = 1'b1; br_taken = 1'b0;
    #1;
    checks++; if (stall !== 1'b1 || issue !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL bnt_resolve: got stall=%b issue=%b flush=%b want 1 0 0", stall, issue, flush); end
    cyc();
    br_resolved = 1'b0;
    #1;
    checks++; if (issue !== 1'b1 || flush !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL bnt_resume: got issue=%b flush=%b stall=%b want 1 0 0", issue, flush, stall); end
    cyc();
    wb_clear(3'd3);
  endtask

  task automatic test_branch_taken();
    drive(1'b1, mk(1, 2, 0), 1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b1, mk(1, 2, 3), 1'b1, 1'b1, 1'b0);
    br_resolved = 1'b1; br_taken = 1'b1;  // cycle K
    #1;
    checks++; if (flush !== 1'b0 || stall !== 1'b1 || issue !== 1'b0) begin errors++;
      $display("FAIL bt_k: got flush=%b stall=%b issue=%b want 0 1 0", flush, stall, issue); end
    cyc();
    br_resolved = 1'b1; br_taken = 1'b0;  // K+1, ignored in flush
    #1;
    checks++; if (flush !== 1'b1 || stall !== 1'b1 || issue !== 1'b0) begin errors++;
      $display("FAIL bt_k1: got flush=%b stall=%b issue=%b want 1 1 0", flush, stall, issue); end
    cyc();
    br_resolved = 1'b1; br_taken = 1'b1;  // K+2, ignored in flush
    #1;
    checks++; if (flush !== 1'b1 || stall !== 1'b1 || issue !== 1'b0) begin errors++;
      $display("FAIL bt_k2: got flush=%b stall=%b issue=%b want 1 1 0", flush, stall, issue); end
    cyc();
    br_resolved = 1'b0; br_taken = 1'b0;
    #1;
    checks++; if (flush !== 1'b0 || issue !== 1'b1 || stall !== 1'b0) begin errors++;
      $display("FAIL bt_k3: got flush=%b issue=%b stall=%b want 0 1 0", flush, issue, stall); end
    cyc();
    wb_clear(3'd3);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, mk(1, 2, 3), 1'b1, 1'b1, 1'b0);
    cyc();
    drive(1'b1, mk(1, 2, 0), 1'b0, 1'b0, 1'b1);
    cyc();
    idle();
    br_resolved = 1'b1; br_taken = 1'b1;
    cyc();
    br_resolved = 1'b0; br_taken = 1'b0;
    #1;
    checks++; if (flush !== 1'b1 || busy_mask !== 8'h08) begin errors++;
      $display("FAIL rm_in_flush: got flush=%b busy=%h want 1 08", flush, busy_mask); end
    rst = 1'b1;
    #1;
    checks++; if (flush !== 1'b0 || stall !== 1'b0 || busy_mask !== 8'h00) begin errors++;
      $display("FAIL rm_reset: got flush=%b stall=%b busy=%h want 0 0 00", flush, stall, busy_mask); end
    cyc();
    rst = 1'b0;
    drive(1'b1, mk(1, 2, 3), 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (issue !== 1'b1 || flush !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL rm_after: got issue=%b flush=%b stall=%b want 1 0 0", issue, flush, stall); end
    cyc();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_raw();
    test_itype();
    test_reg0();
    test_branch_nt();
    test_branch_taken();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

endmodule
